req_chan_rcvr: RTL and testbench

- Responder-side endpoint of the request (a_*) channel.
- Accepts requests from the granted initiator with the a_valid/a_ready handshake and stores each request's id and address in a small in-order FIFO.
- Presents the oldest stored request to slave-side logic (memory/peripheral controller), which consumes it with a take pulse.
- Decouples bus acceptance from slave service latency.

---
 rtl/req_chan_rcvr.sv | 103 ++++++++++
 tb/tb_req_chan_rcvr.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/req_chan_rcvr.sv
// Request-channel receiver: accepts a_* requests into an in-order FIFO and presents the head to slave logic.
// Optional atomic-request rejection is enabled by defining REQC_S_ATOP_CHK_EN.
module req_chan_rcvr #(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [3:0]            a_id,
  input  logic [31:0]           a_addr,
  input  logic [5:0]            a_atop,
  output logic                  rq_valid,
  output logic [3:0]            rq_id,
  output logic [31:0]           rq_addr,
  input  logic                  rq_take,
  output logic [DEPTH_LOG2:0]   rq_cnt,
  output logic                  atop_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
  } req_t;

  req_t                  mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
  logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
  logic [DEPTH_LOG2:0]   cnt_q, cnt_d;
  logic                  push, store, pop;

  // Handshake signals depend only on registered count, never on a_valid or rq_take.
  assign a_ready  = (cnt_q != FULL_CNT);
  assign rq_valid = (cnt_q != '0);
  assign rq_cnt   = cnt_q;
  assign push     = a_valid & a_ready;
  assign pop      = rq_take & rq_valid;

  // Head is masked while empty so stale storage never leaks onto the outputs.
  assign rq_id   = rq_valid ? mem_q[rptr_q].id   : '0;
  assign rq_addr = rq_valid ? mem_q[rptr_q].addr : '0;

`ifdef REQC_S_ATOP_CHK_EN
  logic atop_err_q;

  assign store    = push & (a_atop == 6'b000000);
  assign atop_err = atop_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      atop_err_q <= 1'b0;
    end else if (push && (a_atop != 6'b000000)) begin
      atop_err_q <= 1'b1;
    end
  end
`else
  logic unused_atop;

  assign store       = push;
  assign atop_err    = 1'b0;
  assign unused_atop = ^a_atop;
`endif

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (store) wptr_d = wptr_q + PTR_ONE;
    if (pop)   rptr_d = rptr_q + PTR_ONE;
    case ({store, pop})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // NOTE: storage is deliberately not reset; count/pointers define validity and outputs are masked when empty.
  always_ff @(posedge clk) begin
    if (store) begin
      mem_q[wptr_q] <= '{id: a_id, addr: a_addr};
    end
  end

endmodule

// File: tb/tb_req_chan_rcvr.sv
// Self-checking bench for req_chan_rcvr: directed test-plan sequences plus randomized traffic
// compared against a queue-based reference model.
module tb_req_chan_rcvr;

  localparam int DEPTH_LOG2 = 2;
  localparam int DEPTH      = 1 << DEPTH_LOG2;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                a_valid;
  logic                a_ready;
  logic [3:0]          a_id;
  logic [31:0]         a_addr;
  logic [5:0]          a_atop;
  logic                rq_valid;
  logic [3:0]          rq_id;
  logic [31:0]         rq_addr;
  logic                rq_take;
  logic [DEPTH_LOG2:0] rq_cnt;
  logic                atop_err;

  req_chan_rcvr #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .a_id     (a_id),
    .a_addr   (a_addr),
    .a_atop   (a_atop),
    .rq_valid (rq_valid),
    .rq_id    (rq_id),
    .rq_addr  (rq_addr),
    .rq_take  (rq_take),
    .rq_cnt   (rq_cnt),
    .atop_err (atop_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
  } ent_t;

  ent_t q[$];
  bit   err_m;
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check("a_ready",  32'(a_ready),  32'(q.size() < DEPTH));
    check("rq_valid", 32'(rq_valid), 32'(q.size() != 0));
    check("rq_cnt",   32'(rq_cnt),   32'(q.size()));
    check("rq_id",    32'(rq_id),    (q.size() != 0) ? 32'(q[0].id) : 32'h0);
    check("rq_addr",  rq_addr,       (q.size() != 0) ? q[0].addr : 32'h0);
    check("atop_err", 32'(atop_err), 32'(err_m));
  endtask

  // One clock cycle: check current outputs, drive inputs, advance the model at the edge.
  task automatic cycle(input logic v, input logic [3:0] id, input logic [31:0] addr,
                       input logic [5:0] atop, input logic take);
    bit acc, pp, keep;
    check_outputs();
    a_valid = v; a_id = id; a_addr = addr; a_atop = atop; rq_take = take;
    acc  = v && (q.size() < DEPTH);
    pp   = take && (q.size() != 0);
`ifdef REQC_S_ATOP_CHK_EN
    keep = (atop == 6'b000000);
`else
    keep = 1'b1;
`endif
    @(posedge clk);
    if (pp) void'(q.pop_front());
    if (acc && keep) q.push_back('{id: id, addr: addr});
    if (acc && !keep) err_m = 1'b1;
    @(negedge clk);
    a_valid = 1'b0; rq_take = 1'b0; a_atop = '0;
  endtask

  task automatic push(input logic [31:0] addr);
    cycle(1'b1, addr[3:0], addr, 6'b0, 1'b0);
  endtask

  task automatic take();
    cycle(1'b0, 4'h0, 32'h0, 6'b0, 1'b1);
  endtask

  task automatic idle();
    cycle(1'b0, 4'h0, 32'h0, 6'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * DEPTH && q.size() != 0; i++) take();
  endtask

  initial begin
    rst_n = 1'b0; a_valid = 1'b0; a_id = '0; a_addr = '0; a_atop = '0; rq_take = 1'b0;
    err_m = 1'b0;
    #12;
    check("rst_a_ready", 32'(a_ready), 32'h1);
    check("rst_rq_valid", 32'(rq_valid), 32'h0);
    check("rst_rq_addr", rq_addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single request
    cycle(1'b1, 4'b0101, 32'h0000_1000, 6'b0, 1'b0);
    check("single_id", 32'(rq_id), 32'h5);
    check("single_addr", rq_addr, 32'h0000_1000);
    check("single_cnt", 32'(rq_cnt), 32'h1);
    take();
    check("single_empty", 32'(rq_valid), 32'h0);

    // Fill to full, held-off 5th request, take while full
    push(32'h10); push(32'h20); push(32'h30); push(32'h40);
    check("full_ready", 32'(a_ready), 32'h0);
    check("full_cnt", 32'(rq_cnt), 32'h4);
    cycle(1'b1, 4'h0, 32'h50, 6'b0, 1'b0);
    check("held_cnt", 32'(rq_cnt), 32'h4);
    cycle(1'b1, 4'h0, 32'h50, 6'b0, 1'b1);
    check("freed_ready", 32'(a_ready), 32'h1);
    push(32'h50);
    check("after50_cnt", 32'(rq_cnt), 32'h4);
    check("fill_pop0", rq_addr, 32'h20); take();
    check("fill_pop1", rq_addr, 32'h30); take();
    check("fill_pop2", rq_addr, 32'h40); take();
    check("fill_pop3", rq_addr, 32'h50); take();

    // Simultaneous push/pop with pointer wrap
    push(32'hF0); push(32'hF1);
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 4'(i), 32'h100 + 32'(i), 6'b0, 1'b1);
      check("simul_cnt", 32'(rq_cnt), 32'h2);
    end
    check("simul_head", rq_addr, 32'h104);
    drain();

    // Empty takes are ignored
    take(); take(); take();
    check("empty_cnt", 32'(rq_cnt), 32'h0);
    push(32'h77);
    check("empty_then_push", rq_addr, 32'h77);
    drain();

    // Asynchronous reset mid-operation
    push(32'h1); push(32'h2); push(32'h3);
    check("pre_rst_cnt", 32'(rq_cnt), 32'h3);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(rq_valid), 32'h0);
    check("mid_rst_cnt", 32'(rq_cnt), 32'h0);
    check("mid_rst_ready", 32'(a_ready), 32'h1);
    check("mid_rst_addr", rq_addr, 32'h0);
    q.delete(); err_m = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    push(32'hA0);
    check("post_rst_first", rq_addr, 32'hA0);
    drain();

    // Atomic request handling
    cycle(1'b1, 4'h1, 32'h200, 6'b100000, 1'b0);
`ifdef REQC_S_ATOP_CHK_EN
    check("atop_err_set", 32'(atop_err), 32'h1);
    check("atop_cnt0", 32'(rq_cnt), 32'h0);
`else
    check("atop_err_off", 32'(atop_err), 32'h0);
    check("atop_cnt1", 32'(rq_cnt), 32'h1);
`endif
    push(32'h204);
`ifdef REQC_S_ATOP_CHK_EN
    check("atop_second_cnt", 32'(rq_cnt), 32'h1);
    check("atop_second_addr", rq_addr, 32'h204);
    check("atop_err_sticky", 32'(atop_err), 32'h1);
`else
    check("atop_both_cnt", 32'(rq_cnt), 32'h2);
    check("atop_first_addr", rq_addr, 32'h200);
`endif
    drain();

    // Randomized traffic, alternating fill-biased and drain-biased phases
    for (int i = 0; i < 600; i++) begin
      logic v, t;
      logic [5:0] at;
      if ((i / 50) % 2 == 0) begin
        v = ($urandom_range(0, 3) != 0);
        t = ($urandom_range(0, 3) == 0);
      end else begin
        v = ($urandom_range(0, 3) == 0);
        t = ($urandom_range(0, 3) != 0);
      end
      at = ($urandom_range(0, 15) == 0) ? 6'($urandom_range(1, 63)) : 6'b0;
      cycle(v, 4'($urandom), $urandom, at, t);
    end
    idle();
    check_outputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
